micro_sequencer: RTL

//  Parametrised Am2910-class microprogram sequencer: decodes the 4-bit next-address instruction,

---
 rtl/micro_seq_pkg.sv | 37 +++
 rtl/micro_stack.sv | 61 ++++++
 rtl/micro_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/micro_seq_pkg.sv
// Shared encodings for the microprogram sequencer: opcodes, stack ops, Y sources, R ops.
// Pure constants; no logic, no latency.
// Imported by micro_stack and micro_sequencer.
package micro_seq_pkg;

  localparam logic [3:0] OP_JZ   = 4'h0;
  localparam logic [3:0] OP_CJS  = 4'h1;
  localparam logic [3:0] OP_JMAP = 4'h2;
  localparam logic [3:0] OP_CJP  = 4'h3;
  localparam logic [3:0] OP_PUSH = 4'h4;
  localparam logic [3:0] OP_JSRP = 4'h5;
  localparam logic [3:0] OP_CJV  = 4'h6;
  localparam logic [3:0] OP_JRP  = 4'h7;
  localparam logic [3:0] OP_RFCT = 4'h8;
  localparam logic [3:0] OP_RPCT = 4'h9;
  localparam logic [3:0] OP_CRTN = 4'hA;
  localparam logic [3:0] OP_CJPP = 4'hB;
  localparam logic [3:0] OP_LDCT = 4'hC;
  localparam logic [3:0] OP_LOOP = 4'hD;
  localparam logic [3:0] OP_CONT = 4'hE;
  localparam logic [3:0] OP_TWB  = 4'hF;

  localparam logic [1:0] STK_HOLD  = 2'd0;
  localparam logic [1:0] STK_PUSH  = 2'd1;
  localparam logic [1:0] STK_POP   = 2'd2;
  localparam logic [1:0] STK_CLEAR = 2'd3;

  localparam logic [1:0] Y_UPC = 2'd0;
  localparam logic [1:0] Y_D   = 2'd1;
  localparam logic [1:0] Y_R   = 2'd2;
  localparam logic [1:0] Y_F   = 2'd3;

  localparam logic [1:0] R_HOLD = 2'd0;
  localparam logic [1:0] R_LOAD = 2'd1;
  localparam logic [1:0] R_DEC  = 2'd2;

endpackage

// File: rtl/micro_stack.sv
// LIFO return-address stack with clear, saturating push (overwrites top) and guarded pop.
// Top-of-stack is combinational; updates land one cycle after the op.
// No backpressure: en=0 freezes contents, error events only pulse while en=1.
module micro_stack
  import micro_seq_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              ovf_evt,
  output logic              udf_evt
);

  localparam int PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [PTR_W-1:0]  cnt;
  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic              empty;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  wr_idx;

  assign empty   = (cnt == '0);
  assign full    = (cnt == PTR_W'(STACK_DEPTH));
  assign top_idx = IDX_W'(cnt - PTR_W'(1));
  // A push while full lands on the current top entry rather than growing.
  assign wr_idx  = full ? IDX_W'(STACK_DEPTH - 1) : IDX_W'(cnt);
  assign top     = empty ? '0 : mem[top_idx];

  assign ovf_evt = en && (op == STK_PUSH) && full;
  assign udf_evt = en && (op == STK_POP) && empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int k = 0; k < STACK_DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (en) begin
      case (op)
        STK_CLEAR: cnt <= '0;
        STK_PUSH: begin
          mem[wr_idx] <= din;
          if (!full) cnt <= cnt + PTR_W'(1);
        end
        STK_POP: begin
          if (!empty) cnt <= cnt - PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Am2910-class next-address sequencer: opcode decode, Y mux, uPC, loop counter R, stack.
// Zero-cycle decode to y/enables; uPC, R, stack and flags update on the next rising edge.
// No backpressure: hold=1 freezes all state while y keeps tracking the inputs.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int CNT_W       = 12,
  parameter int STACK_DEPTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        i,
  input  logic [ADDR_W-1:0] d,
  input  logic              cc_n,
  input  logic              ccen_n,
  input  logic              ci,
  input  logic              rld_n,
  input  logic              hold,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] y,
  output logic              pl_n,
  output logic              map_n,
  output logic              vect_n,
  output logic              full_n,
  output logic              ovf,
  output logic              udf
);

  logic [ADDR_W-1:0] upc;
  logic [CNT_W-1:0]  r;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full;
  logic              ovf_evt;
  logic              udf_evt;

  logic              pass;
  logic              rz;
  logic [1:0]        y_src;
  logic              y_zero;
  logic [1:0]        stk_op;
  logic [1:0]        r_op;

  assign pass = ccen_n | ~cc_n;
  assign rz   = (r == '0);

  always_comb begin
    y_src  = Y_UPC;
    y_zero = 1'b0;
    stk_op = STK_HOLD;
    r_op   = R_HOLD;
    pl_n   = 1'b0;
    map_n  = 1'b1;
    vect_n = 1'b1;
    case (i)
      OP_JZ: begin
        y_zero = 1'b1;
        stk_op = STK_CLEAR;
      end
      OP_CJS: begin
        if (pass) begin
          y_src  = Y_D;
          stk_op = STK_PUSH;
        end
      end
      OP_JMAP: begin
        y_src = Y_D;
        pl_n  = 1'b1;
        map_n = 1'b0;
      end
      OP_CJP: begin
        if (pass) y_src = Y_D;
      end
      OP_PUSH: begin
        stk_op = STK_PUSH;
        if (pass) r_op = R_LOAD;
      end
      OP_JSRP: begin
        stk_op = STK_PUSH;
        y_src  = pass ? Y_D : Y_R;
      end
      OP_CJV: begin
        pl_n   = 1'b1;
        vect_n = 1'b0;
        if (pass) y_src = Y_D;
      end
      OP_JRP: begin
        y_src = pass ? Y_D : Y_R;
      end
      OP_RFCT: begin
        if (!rz) begin
          y_src = Y_F;
          r_op  = R_DEC;
        end else begin
          stk_op = STK_POP;
        end
      end
      OP_RPCT: begin
        if (!rz) begin
          y_src = Y_D;
          r_op  = R_DEC;
        end
      end
      OP_CRTN: begin
        if (pass) begin
          y_src  = Y_F;
          stk_op = STK_POP;
        end
      end
      OP_CJPP: begin
        if (pass) begin
          y_src  = Y_D;
          stk_op = STK_POP;
        end
      end
      OP_LDCT: begin
        r_op = R_LOAD;
      end
      OP_LOOP: begin
        if (pass) stk_op = STK_POP;
        else      y_src  = Y_F;
      end
      OP_CONT: ;
      OP_TWB: begin
        if (pass) begin
          stk_op = STK_POP;
        end else if (!rz) begin
          y_src = Y_F;
          r_op  = R_DEC;
        end else begin
          y_src  = Y_D;
          stk_op = STK_POP;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    y = upc;
    if (y_zero) begin
      y = '0;
    end else begin
      case (y_src)
        Y_D:     y = d;
        Y_R:     y = ADDR_W'(r);
        Y_F:     y = stk_top;
        default: y = upc;
      endcase
    end
  end

  micro_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (~hold),
    .op      (stk_op),
    .din     (upc),
    .top     (stk_top),
    .full    (stk_full),
    .ovf_evt (ovf_evt),
    .udf_evt (udf_evt)
  );

  assign full_n = ~stk_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc <= '0;
      r   <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (!hold) begin
      upc <= y + ADDR_W'(ci);
      // External rld_n load wins over anything the opcode asks of R.
      if (!rld_n) begin
        r <= d[CNT_W-1:0];
      end else begin
        case (r_op)
          R_LOAD:  r <= d[CNT_W-1:0];
          R_DEC:   r <= r - CNT_W'(1);
          default: ;
        endcase
      end
      if (ovf_evt)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (udf_evt)      udf <= 1'b1;
      else if (clr_err) udf <= 1'b0;
    end
  end

endmodule
